msk_cst_stream_encoder: RTL and testbench

Streaming encoder that turns public (non-sensitive) words into d-share Boolean sharings for the masked datapath. Each word is encoded either trivially, as (x, 0, ..., 0), or with fresh randomness, as (x^r1^...^r(d-1), r1, ..., r(d-1)), selected per word. Encoded words pass through a small output FIFO with valid/ready handshakes and are grouped into frames of NWORDS words. The block sits between the public-data/constant loaders and the masked core inputs.

---
 rtl/msk_cst_stream_encoder_if.sv | 32 +++
 rtl/msk_cst_stream_encoder.sv | 82 ++++++++
 tb/tb_msk_cst_stream_encoder.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/msk_cst_stream_encoder_if.sv
// Stream bundle for the public-word share encoder.
// Ports: input word/mask/valid/ready, randomness valid/ready, output shares/last/valid/ready.
interface msk_cst_stream_encoder_if #(
    parameter int d     = 2,
    parameter int count = 32
);
    logic [count-1:0]       in_data;
    logic                   in_mask;
    logic                   in_valid;
    logic                   in_ready;
    logic [(d-1)*count-1:0] rnd;
    logic                   rnd_valid;
    logic                   rnd_ready;
    logic [count*d-1:0]     out_sh;
    logic                   out_last;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output in_data, in_mask, in_valid,
        output rnd, rnd_valid, out_ready,
        input  in_ready, rnd_ready,
        input  out_sh, out_last, out_valid
    );

    modport slave (
        input  in_data, in_mask, in_valid,
        input  rnd, rnd_valid, out_ready,
        output in_ready, rnd_ready,
        output out_sh, out_last, out_valid
    );
endinterface

// File: rtl/msk_cst_stream_encoder.sv
// Encodes public words into d-share Boolean sharings (trivial or fresh-random),
// buffers them in a DEPTH-entry FIFO and tags every NWORDS-th word as frame last.
// Ports: clk, rst (sync, active high), bus (slave side of the stream bundle).
module msk_cst_stream_encoder #(
    parameter int d      = 2,
    parameter int count  = 32,
    parameter int NWORDS = 4,
    parameter int DEPTH  = 2
) (
    input logic                     clk,
    input logic                     rst,
    msk_cst_stream_encoder_if.slave bus
);
    localparam int WW = count * d;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);

    logic [WW-1:0]    mem_sh [DEPTH];
    logic [DEPTH-1:0] mem_last;
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [CW-1:0]    wcnt;

    logic [WW-1:0] enc;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          wlast;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;

    // Shares 1..d-1 come straight from rnd (gated off for trivial words),
    // share 0 absorbs their XOR so the sharing recombines to x.
    for (genvar i = 0; i < count; i++) begin : g_bit
        logic [d-2:0] r;
        assign r = bus.rnd[i*(d-1) +: (d-1)] & {(d-1){bus.in_mask}};
        assign enc[i*d +: d] = {r, bus.in_data[i] ^ (^r)};
    end

    assign waddr = wptr[AW-1:0];
    assign raddr = rptr[AW-1:0];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (waddr == raddr);
    assign wlast = (wcnt == LAST_IDX);

    // No bypass: in_ready looks only at occupancy and rnd availability.
    assign bus.in_ready  = !full && (!bus.in_mask || bus.rnd_valid);
    assign bus.rnd_ready = bus.in_valid && bus.in_mask
                           && !full && bus.rnd_valid;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            wcnt     <= '0;
            mem_last <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_sh[k] <= '0;
            end
        end else begin
            if (push) begin
                mem_sh[waddr]   <= enc;
                mem_last[waddr] <= wlast;
                wptr            <= wptr + (AW+1)'(1);
                wcnt            <= wlast ? '0 : wcnt + CW'(1);
            end
            if (pop) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

    // Head is masked to zero when invalid so stale shares never leak.
    assign bus.out_valid = !empty;
    assign bus.out_sh    = bus.out_valid ? mem_sh[raddr] : '0;
    assign bus.out_last  = bus.out_valid && mem_last[raddr];
endmodule

// File: tb/tb_msk_cst_stream_encoder.sv
// Scoreboard bench for msk_cst_stream_encoder (d=2, count=8, NWORDS=4, DEPTH=2).
// Driver pushes expected words on acceptance; a negedge monitor pops and compares.
module tb_msk_cst_stream_encoder;
    localparam int D = 2;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   miss = 0;
    int   rr_cnt = 0;
    int   fcnt = 0;
    logic [24:0] exp_q [$];
    logic [24:0] e;

    always #5 clk = ~clk;

    msk_cst_stream_encoder_if #(.d(D), .count(W)) bus ();

    msk_cst_stream_encoder #(
        .d(D), .count(W), .NWORDS(4), .DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    function automatic logic [15:0] ilv(input logic [7:0] s0, input logic [7:0] s1);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[2*i]   = s0[i];
            r[2*i+1] = s1[i];
        end
        return r;
    endfunction

    function automatic logic [7:0] recomb(input logic [15:0] sh);
        logic [7:0] x;
        for (int i = 0; i < 8; i++) begin
            x[i] = sh[2*i] ^ sh[2*i+1];
        end
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vecs++;
        if (act !== req) begin
            miss++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rnd_ready === 1'b1) rr_cnt++;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    vecs++;
                    miss++;
                    $display("FAIL unexpected_pop: got %h want none", bus.out_sh);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_sh", 32'(bus.out_sh), 32'(e[15:0]));
                    chk("pop_last", 32'(bus.out_last), 32'(e[16]));
                    chk("pop_xor", 32'(recomb(bus.out_sh)), 32'(e[24:17]));
                end
            end else if (!bus.out_valid) begin
                chk("idle_sh_zero", 32'(bus.out_sh), 32'h0);
                chk("idle_last_zero", 32'(bus.out_last), 32'h0);
            end
        end
    end

    task automatic send(input logic [7:0] x, input logic m,
                        input logic [7:0] r, input logic [7:0] s0);
        int t;
        bus.in_data   = x;
        bus.in_mask   = m;
        bus.rnd       = r;
        bus.rnd_valid = 1'b1;
        bus.in_valid  = 1'b1;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            vecs++;
            miss++;
            $display("FAIL accept_timeout: in_ready got 0 want 1");
        end else begin
            chk("rnd_ready_on_accept", 32'(bus.rnd_ready), 32'(m));
            exp_q.push_back({x, (fcnt == 3), ilv(s0, m ? r : 8'h00)});
            fcnt = (fcnt + 1) % 4;
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.rnd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rr0;
        int t;
        logic [7:0] v;
        bus.in_data   = '0;
        bus.in_mask   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.rnd       = '0;
        bus.rnd_valid = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_sh", 32'(bus.out_sh), 32'h0);
        chk("rst_out_last", 32'(bus.out_last), 32'h0);
        chk("rst_in_ready_triv", 32'(bus.in_ready), 32'h1);
        bus.in_mask = 1'b1;
        #1;
        chk("rst_in_ready_mask_nornd", 32'(bus.in_ready), 32'h0);
        bus.rnd_valid = 1'b1;
        #1;
        chk("rst_in_ready_mask_rnd", 32'(bus.in_ready), 32'h1);
        chk("rst_rnd_ready_noval", 32'(bus.rnd_ready), 32'h0);
        bus.in_mask   = 1'b0;
        bus.rnd_valid = 1'b0;
        @(posedge clk);
        #1;

        // trivial 0xA5
        send(8'hA5, 1'b0, 8'h00, 8'hA5);
        @(negedge clk);
        chk("lat_valid_triv", 32'(bus.out_valid), 32'h1);
        chk("lat_sh_triv", 32'(bus.out_sh), 32'h4411);
        chk("lat_last_triv", 32'(bus.out_last), 32'h0);
        @(posedge clk);
        #1;

        // masked 0xA5 with rnd 0x3C
        rr0 = rr_cnt;
        send(8'hA5, 1'b1, 8'h3C, 8'h99);
        @(negedge clk);
        chk("lat_sh_mask", 32'(bus.out_sh), 32'h4BE1);
        chk("rnd_once", 32'(rr_cnt - rr0), 32'h1);
        @(posedge clk);
        #1;

        // backpressure
        bus.out_ready = 1'b0;
        send(8'h11, 1'b0, 8'h00, 8'h11);
        send(8'h22, 1'b0, 8'h00, 8'h22);
        bus.in_data  = 8'h33;
        bus.in_mask  = 1'b0;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_in_ready", 32'(bus.in_ready), 32'h0);
            chk("hold_valid", 32'(bus.out_valid), 32'h1);
            chk("hold_sh", 32'(bus.out_sh), 32'h0101);
            chk("hold_last", 32'(bus.out_last), 32'h0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(8'h33, 1'b1, 8'h0F, 8'h3C);
        repeat (4) @(posedge clk);
        #1;
        chk("drain_empty", 32'(exp_q.size()), 32'h0);

        // reset, then 9 back-to-back words
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        fcnt = 0;
        for (int k = 0; k < 9; k++) begin
            v = 8'(8'h40 + k);
            send(v, 1'b0, 8'h00, v);
        end

        // masked word stalled on rnd_valid
        bus.in_data   = 8'h5A;
        bus.in_mask   = 1'b1;
        bus.rnd       = 8'hC3;
        bus.rnd_valid = 1'b0;
        bus.in_valid  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(bus.in_ready), 32'h0);
            chk("stall_rnd_ready", 32'(bus.rnd_ready), 32'h0);
        end
        @(posedge clk);
        #1;
        send(8'h5A, 1'b1, 8'hC3, 8'h99);
        send(8'h77, 1'b0, 8'hFF, 8'h77);

        // reset with two words buffered mid-frame
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(8'h81, 1'b0, 8'h00, 8'h81);
        send(8'h82, 1'b0, 8'h00, 8'h82);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        fcnt = 0;
        @(negedge clk);
        chk("rst2_valid", 32'(bus.out_valid), 32'h0);
        chk("rst2_sh", 32'(bus.out_sh), 32'h0);
        chk("rst2_last", 32'(bus.out_last), 32'h0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            v = 8'(8'h90 + k);
            send(v, 1'b0, 8'h00, v);
        end

        t = 0;
        while (exp_q.size() != 0 && t < 20) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("final_drain", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
